// File: rtl/shift_add_mul4.sv
// 4x4 unsigned sequential multiplier: one shift-add step per clock, four steps per product.
// Handshake: start/ready on the input side, out_valid/out_ready on the result side.
module shift_add_mul4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] product,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] mq_q, mq_d;
  logic [3:0] mcand_q, mcand_d;
  logic [1:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [4:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 4'd0;
      mq_q    <= 4'd0;
      mcand_q <= 4'd0;
      cnt_q   <= 2'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Conditional add of the multiplicand; bit 4 is the carry that shifts into acc[3].
  assign sum = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : 4'd0)};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mcand_d = a;
          mq_d    = b;
          acc_d   = 4'd0;
          cnt_d   = 2'd0;
          carry_d = 1'b0;
        end
      end
      RUN: begin
        carry_d = sum[4];
        acc_d   = sum[4:1];
        mq_d    = {sum[0], mq_q[3:1]};
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign product   = {acc_q, mq_q};

endmodule

// File: tb/tb_shift_add_mul4.sv
// Randomized + directed bench for shift_add_mul4; reference is plain a*b with
// handshake timing checked against the accept/4-step/DONE protocol.
module tb_shift_add_mul4;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [3:0] a, b;
  logic       ready, busy, out_valid;
  logic [7:0] product;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_add_mul4 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_product"}, product, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  // noisy: hammer start=1, a=b=15 while the operation is in flight.
  task automatic do_mul(input logic [3:0] ta, input logic [3:0] tbv, input int hold,
                        input bit noisy, input bit ack_start);
    int         edges = 0;
    int         bcnt  = 0;
    logic [7:0] exp_p;
    logic [7:0] held;
    exp_p = 8'(int'(ta) * int'(tbv));
    chk("ready_pre", ready, 1);
    start = 1'b1; a = ta; b = tbv; out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && edges < 20) begin
      chk("onehot", 32'($countones({ready, busy, out_valid}) <= 1), 1);
      if (busy) bcnt++;
      if (noisy) begin
        start = 1'b1; a = 4'hF; b = 4'hF;
      end else begin
        start = 1'b0; a = 4'($urandom); b = 4'($urandom);
      end
      out_ready = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    out_ready = 1'b0;
    chk("latency", edges, 4);
    chk("busy_cycles", bcnt, 4);
    chk("product", product, exp_p);
    held = product;
    for (int i = 0; i < hold; i++) begin
      start = noisy ? 1'b1 : 1'($urandom);
      a = 4'($urandom); b = 4'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_product", product, held);
    end
    out_ready = 1'b1;
    start     = ack_start;
    @(negedge clk);
    chk("ack_ready", ready, 1);
    chk("ack_valid", out_valid, 0);
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; a = 4'd0; b = 4'd0;
    #1;
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    chk_reset_vals("por_hold");
    rst = 1'b0;

    // Directed corner operands
    do_mul(4'd15, 4'd15, 0, 1'b0, 1'b0);
    do_mul(4'd13, 4'd11, 0, 1'b0, 1'b0);
    do_mul(4'd0,  4'd9,  0, 1'b0, 1'b0);
    do_mul(4'd9,  4'd0,  0, 1'b0, 1'b0);
    do_mul(4'd1,  4'd15, 0, 1'b0, 1'b0);
    // start and new operands ignored while running, then held result in DONE
    do_mul(4'd6,  4'd7,  0, 1'b1, 1'b0);
    do_mul(4'd6,  4'd7,  10, 1'b1, 1'b1);
    chk("no_restart_after_ack", ready, 1);

    // Asynchronous reset between edges after two RUN steps
    start = 1'b1; a = 4'd7; b = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    @(posedge clk);
    #1 chk_reset_vals("rst_held");
    @(negedge clk);
    rst = 1'b0;
    do_mul(4'd3, 4'd5, 0, 1'b0, 1'b0);

    // Random operations with random DONE hold and noise
    for (int i = 0; i < 40; i++)
      do_mul(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom));

    // Exhaustive, back-to-back
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        do_mul(4'(x), 4'(y), 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
